upower_fetch_unit: RTL and testbench
====================================

UPOWER_FETCH_UNIT -- requirements
Module: upower_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter WAIT_LIMIT, default 15, meaning the maximum number of cycles without imem_ack before a fetch is declared failed.
REQ-003 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address being fetched.
REQ-007 imem_ack  input  1  instruction memory returns data this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 redirect  input  1  taken branch/jump from downstream (Branch & PCSrc).
REQ-010 redirect_target  input  32  new PC when redirect=1.
REQ-011 instr_ready  input  1  decode/control stage accepts the held instruction.
REQ-012 instr_valid  output  1  instr, po and pc_out are valid.
REQ-013 instr  output  32  registered instruction word.
REQ-014 po  output  6  primary opcode, instr[31:26], for the control unit.
REQ-015 pc_out  output  32  address the held instruction was fetched from.
REQ-016 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, HOLD and ERR.
REQ-018 IDLE SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-019 In FETCH, imem_req=1 and imem_addr=pc; all other states drive imem_req=0.
REQ-020 On FETCH with imem_ack=1 and redirect=0, the block SHALL register instr<=imem_rdata, po<=imem_rdata[31:26], pc_out<=pc and pc<=pc+4, then go to HOLD.
REQ-021 Latency SHALL be one cycle: ack in cycle n gives instr_valid=1 in cycle n+1.
REQ-022 In HOLD, instr_valid=1 and instr/po/pc_out SHALL remain stable until instr_ready=1.
REQ-023 On HOLD with instr_ready=1, the FSM SHALL go to FETCH, so that imem_req is high in the next cycle and instr_valid=0 that cycle.
REQ-024 PC arithmetic SHALL be modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-025 redirect=1 in FETCH or HOLD SHALL take priority over ack and ready: pc<=redirect_target with bits[1:0] forced to 0, and the FSM goes to FETCH.
REQ-026 An imem_ack in the same cycle as redirect SHALL be discarded, with no instr update and no HOLD entry.
REQ-027 redirect SHALL be ignored in IDLE and ERR.
REQ-028 A wait counter SHALL clear on entry to FETCH, on ack and on redirect, and SHALL increment on each FETCH cycle without ack.
REQ-029 When the wait counter reaches WAIT_LIMIT, the FSM SHALL go to ERR and set fetch_err=1.
REQ-030 ERR SHALL be terminal until reset: imem_req=0, instr_valid=0, fetch_err=1.
REQ-031 instr_valid, imem_req and fetch_err SHALL be registered or decoded from registered state only, with no combinational path from any input.

Reset
REQ-032 While rst_n=0, the block SHALL hold state=IDLE, pc=RESET_PC, wait counter=0, instr=0, po=0, pc_out=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC and fetch_err=0.
REQ-033 Reset asserted mid-fetch or mid-hold SHALL abandon the transaction immediately, with outputs taking their reset values asynchronously.
REQ-034 After reset release, the first imem_req SHALL be asserted in the second rising edge's cycle, that is, after the single IDLE cycle.

Verification
REQ-035 Reset release, imem_ack=1 every cycle, instr_ready=1: addresses 0, 4, 8, ...; data 0x7C221A14 gives po=31, pc_out=0 one cycle after ack.
REQ-036 Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> instr, po and pc_out stable, imem_req=0; ready=1 -> next fetch at pc_out+4.
REQ-037 Redirect to 0x0000_1003 in HOLD -> next imem_addr=0x0000_1000 and instr_valid=0 the following cycle; redirect coincident with ack -> data dropped, no HOLD.
REQ-038 Wrap: RESET_PC=32'hFFFF_FFFC with two fetches -> second imem_addr=0.
REQ-039 Timeout: imem_ack=0 for WAIT_LIMIT cycles -> fetch_err=1 and imem_req=0 persist through later acks and redirects; rst_n pulse clears them.
REQ-040 Async reset asserted between clock edges during HOLD -> instr_valid=0 and pc=RESET_PC before the next edge.

Source files
------------

// File: rtl/upower_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, downstream
// redirect and the held-instruction handshake toward decode.
interface upower_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  po;
  logic [31:0] pc_out;
  logic        fetch_err;

  // Fetch unit side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  redirect,
    input  redirect_target,
    input  instr_ready,
    output instr_valid,
    output instr,
    output po,
    output pc_out,
    output fetch_err
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output redirect,
    output redirect_target,
    output instr_ready,
    input  instr_valid,
    input  instr,
    input  po,
    input  pc_out,
    input  fetch_err
  );
endinterface

// File: rtl/upower_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch, one-deep instruction holding
// register, redirect support and a sticky memory-timeout error state.
// WAIT_LIMIT must be at least 1.
module upower_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  upower_fetch_unit_if.master bus
);

  localparam int unsigned WaitW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  // Last count value that still allows another FETCH cycle
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StErr
  } state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [WaitW-1:0]  wait_q;
  logic [31:0]       instr_q;
  logic [5:0]        po_q;
  logic [31:0]       pc_out_q;
  logic              err_q;
  logic [31:0]       target;

  // Redirect targets are word aligned; low two bits are dropped
  assign target = bus.redirect_target & ~32'h0000_0003;

  // FSM, PC, wait counter and holding register; redirect beats ack and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      wait_q   <= '0;
      instr_q  <= '0;
      po_q     <= '0;
      pc_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          wait_q  <= '0;
        end
        StFetch: begin
          if (bus.redirect) begin
            // Any coincident ack is dropped
            pc_q   <= target;
            wait_q <= '0;
          end else if (bus.imem_ack) begin
            instr_q  <= bus.imem_rdata;
            po_q     <= bus.imem_rdata[31:26];
            pc_out_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            wait_q   <= '0;
            state_q  <= StHold;
          end else if (wait_q == WaitLast) begin
            wait_q  <= wait_q + 1'b1;
            err_q   <= 1'b1;
            state_q <= StErr;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StHold: begin
          if (bus.redirect) begin
            pc_q    <= target;
            wait_q  <= '0;
            state_q <= StFetch;
          end else if (bus.instr_ready) begin
            wait_q  <= '0;
            state_q <= StFetch;
          end
        end
        StErr: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.imem_req    = (state_q == StFetch);
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == StHold);
    bus.instr       = instr_q;
    bus.po          = po_q;
    bus.pc_out      = pc_out_q;
    bus.fetch_err   = err_q;
  end

endmodule

// File: tb/tb_upower_fetch_unit.sv
// Directed bench for upower_fetch_unit: reset, streaming, backpressure,
// redirect, PC wrap, timeout and asynchronous reset.
module tb_upower_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  upower_fetch_unit_if f0 ();
  upower_fetch_unit_if f1 ();

  upower_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .WAIT_LIMIT(15)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (f0.master)
  );

  upower_fetch_unit #(
    .RESET_PC  (32'hFFFF_FFFC),
    .WAIT_LIMIT(4)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (f1.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    f0.imem_ack        = 1'b0;
    f0.imem_rdata      = 32'h0;
    f0.redirect        = 1'b0;
    f0.redirect_target = 32'h0;
    f0.instr_ready     = 1'b0;
    f1.imem_ack        = 1'b1;
    f1.imem_rdata      = 32'h0400_0000;
    f1.redirect        = 1'b0;
    f1.redirect_target = 32'h0;
    f1.instr_ready     = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'b0, f0.imem_req}, 32'd0);
    chk("rst_addr", f0.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, f0.instr_valid}, 32'd0);
    chk("rst_instr", f0.instr, 32'h0);
    chk("rst_po", {26'b0, f0.po}, 32'd0);
    chk("rst_pc_out", f0.pc_out, 32'h0);
    chk("rst_err", {31'b0, f0.fetch_err}, 32'd0);
    chk("rst_addr_wrapdut", f1.imem_addr, 32'hFFFF_FFFC);

    // Release: one IDLE cycle without a request
    @(negedge clk);
    rst_n = 1'b1;
    f0.imem_ack    = 1'b1;
    f0.imem_rdata  = 32'h7C22_1A14;
    f0.instr_ready = 1'b1;
    #1;
    chk("idle_req", {31'b0, f0.imem_req}, 32'd0);
    chk("idle_valid", {31'b0, f0.instr_valid}, 32'd0);

    // First fetch at address 0
    @(negedge clk);
    chk("f1_req", {31'b0, f0.imem_req}, 32'd1);
    chk("f1_addr", f0.imem_addr, 32'h0);
    chk("f1_valid", {31'b0, f0.instr_valid}, 32'd0);
    chk("wrap_f1_req", {31'b0, f1.imem_req}, 32'd1);
    chk("wrap_f1_addr", f1.imem_addr, 32'hFFFF_FFFC);

    // One cycle after ack the instruction is held
    @(negedge clk);
    chk("h1_valid", {31'b0, f0.instr_valid}, 32'd1);
    chk("h1_instr", f0.instr, 32'h7C22_1A14);
    chk("h1_po", {26'b0, f0.po}, 32'd31);
    chk("h1_pc_out", f0.pc_out, 32'h0);
    chk("h1_req", {31'b0, f0.imem_req}, 32'd0);
    chk("wrap_h1_pc_out", f1.pc_out, 32'hFFFF_FFFC);
    chk("wrap_h1_po", {26'b0, f1.po}, 32'd1);
    f0.imem_rdata = 32'h1234_5678;

    // Second fetch at 4; wrap DUT fetches address 0
    @(negedge clk);
    chk("f2_req", {31'b0, f0.imem_req}, 32'd1);
    chk("f2_addr", f0.imem_addr, 32'h4);
    chk("f2_valid", {31'b0, f0.instr_valid}, 32'd0);
    chk("wrap_f2_addr", f1.imem_addr, 32'h0);
    chk("wrap_f2_req", {31'b0, f1.imem_req}, 32'd1);

    @(negedge clk);
    chk("h2_instr", f0.instr, 32'h1234_5678);
    chk("h2_po", {26'b0, f0.po}, 32'd4);
    chk("h2_pc_out", f0.pc_out, 32'h4);
    f0.instr_ready = 1'b0;
    f0.imem_rdata  = 32'hDEAD_BEEF;

    // Backpressure: holding register stays put for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, f0.instr_valid}, 32'd1);
      chk("bp_instr", f0.instr, 32'h1234_5678);
      chk("bp_po", {26'b0, f0.po}, 32'd4);
      chk("bp_pc_out", f0.pc_out, 32'h4);
      chk("bp_req", {31'b0, f0.imem_req}, 32'd0);
    end
    f0.instr_ready = 1'b1;

    @(negedge clk);
    chk("bp_next_req", {31'b0, f0.imem_req}, 32'd1);
    chk("bp_next_addr", f0.imem_addr, 32'h8);
    f0.imem_rdata  = 32'h4800_0010;
    f0.instr_ready = 1'b0;

    @(negedge clk);
    chk("h3_pc_out", f0.pc_out, 32'h8);
    chk("h3_instr", f0.instr, 32'h4800_0010);
    // Redirect in HOLD with a misaligned target
    f0.redirect        = 1'b1;
    f0.redirect_target = 32'h0000_1003;
    f0.instr_ready     = 1'b1;

    @(negedge clk);
    chk("rd_hold_addr", f0.imem_addr, 32'h0000_1000);
    chk("rd_hold_valid", {31'b0, f0.instr_valid}, 32'd0);
    chk("rd_hold_req", {31'b0, f0.imem_req}, 32'd1);
    // Redirect coincident with ack: data must be dropped
    f0.redirect_target = 32'h0000_2000;
    f0.imem_ack        = 1'b1;
    f0.imem_rdata      = 32'hAAAA_AAAA;

    @(negedge clk);
    chk("rd_ack_addr", f0.imem_addr, 32'h0000_2000);
    chk("rd_ack_valid", {31'b0, f0.instr_valid}, 32'd0);
    chk("rd_ack_req", {31'b0, f0.imem_req}, 32'd1);
    chk("rd_ack_instr", f0.instr, 32'h4800_0010);
    chk("rd_ack_pc_out", f0.pc_out, 32'h8);
    f0.redirect    = 1'b0;
    f0.imem_rdata  = 32'h3C00_0001;
    f0.instr_ready = 1'b0;

    @(negedge clk);
    chk("h4_pc_out", f0.pc_out, 32'h0000_2000);
    chk("h4_instr", f0.instr, 32'h3C00_0001);
    chk("h4_po", {26'b0, f0.po}, 32'd15);
    f0.imem_ack    = 1'b0;
    f0.instr_ready = 1'b1;

    // Timeout: first FETCH cycle without ack
    @(negedge clk);
    chk("to_start_addr", f0.imem_addr, 32'h0000_2004);
    f0.instr_ready = 1'b0;
    repeat (14) @(negedge clk);
    chk("to_edge_req", {31'b0, f0.imem_req}, 32'd1);
    chk("to_edge_err", {31'b0, f0.fetch_err}, 32'd0);
    @(negedge clk);
    chk("to_err", {31'b0, f0.fetch_err}, 32'd1);
    chk("to_req", {31'b0, f0.imem_req}, 32'd0);
    chk("to_valid", {31'b0, f0.instr_valid}, 32'd0);

    // ERR is terminal: acks and redirects ignored
    f0.imem_ack        = 1'b1;
    f0.redirect        = 1'b1;
    f0.redirect_target = 32'h0000_0040;
    f0.instr_ready     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_sticky", {31'b0, f0.fetch_err}, 32'd1);
      chk("err_req", {31'b0, f0.imem_req}, 32'd0);
      chk("err_valid", {31'b0, f0.instr_valid}, 32'd0);
      chk("err_addr", f0.imem_addr, 32'h0000_2004);
    end

    // Reset pulse clears the error
    @(negedge clk);
    rst_n              = 1'b0;
    f0.imem_ack        = 1'b0;
    f0.redirect        = 1'b0;
    f0.redirect_target = 32'h0;
    f0.instr_ready     = 1'b0;
    #1;
    chk("clr_err", {31'b0, f0.fetch_err}, 32'd0);
    chk("clr_req", {31'b0, f0.imem_req}, 32'd0);
    chk("clr_addr", f0.imem_addr, 32'h0);

    @(negedge clk);
    rst_n         = 1'b1;
    f0.imem_ack   = 1'b1;
    f0.imem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("ar_fetch_req", {31'b0, f0.imem_req}, 32'd1);
    @(negedge clk);
    chk("ar_hold_valid", {31'b0, f0.instr_valid}, 32'd1);
    chk("ar_hold_addr", f0.imem_addr, 32'h4);

    // Asynchronous reset between edges during HOLD
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, f0.instr_valid}, 32'd0);
    chk("ar_addr", f0.imem_addr, 32'h0);
    chk("ar_instr", f0.instr, 32'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
